// File: rtl/axis_adc_decim_frontend.sv
// Multi-channel ADC capture front end: lane registering, format correction,
// per-channel boxcar decimation by 2^D and a 1-deep AXI-Stream output with overrun count.
module axis_adc_decim_lane #(
  parameter int ADC_WIDTH = 14,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_DLOG2 = 8,
  parameter int DW        = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [ADC_WIDTH-1:0] i_raw,
  input  logic                 i_inv,
  input  logic                 i_clr,
  input  logic                 i_first,
  input  logic [DW-1:0]        i_dlog2,
  output logic [OUT_WIDTH-1:0] o_mean
);
  localparam int ACC_W = ADC_WIDTH + MAX_DLOG2;
  localparam logic [ADC_WIDTH-1:0] INV_MASK = {1'b0, {(ADC_WIDTH-1){1'b1}}};

  logic signed [ADC_WIDTH-1:0] r_smp;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     w_sum;

  // Count 0 restarts the sum, so the stale accumulator is never read there.
  assign w_sum  = (i_first ? '0 : r_acc) + {{MAX_DLOG2{r_smp[ADC_WIDTH-1]}}, r_smp};
  // Mean fits in ADC_WIDTH signed, so truncating the shifted sum sign-extends correctly.
  assign o_mean = OUT_WIDTH'(w_sum >>> i_dlog2);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_smp <= '0;
      r_acc <= '0;
    end else begin
      r_smp <= i_inv ? (i_raw ^ INV_MASK) : i_raw;
      r_acc <= i_clr ? '0 : w_sum;
    end
  end
endmodule

module axis_adc_decim_frontend #(
  parameter int NCH       = 2,
  parameter int IN_WIDTH  = 16,
  parameter int ADC_WIDTH = 14,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_DLOG2 = 8
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  output logic                             adc_csn,
  input  logic [NCH*IN_WIDTH-1:0]          adc_dat,
  input  logic                             cfg_enable,
  input  logic                             cfg_invert,
  input  logic [$clog2(MAX_DLOG2+1)-1:0]   cfg_dlog2,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [NCH*OUT_WIDTH-1:0]         m_axis_tdata,
  output logic [15:0]                      sts_overrun
);
  localparam int DW = $clog2(MAX_DLOG2+1);

  logic [NCH-1:0][IN_WIDTH-1:0]  r_dat;
  logic                          r_en1, r_inv1, r_en2;
  logic [DW-1:0]                 r_d1, r_d2, r_dcur;
  logic [MAX_DLOG2-1:0]          r_cnt, w_cmax;
  logic                          w_clr, w_last, w_dump, w_unused;
  logic [NCH-1:0][OUT_WIDTH-1:0] w_mean, r_tdata;
  logic                          r_tvalid;
  logic [15:0]                   r_ovr;

  assign adc_csn       = 1'b1;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign sts_overrun   = r_ovr;
  assign w_unused      = ^r_dat;

  // Config travels down the pipe alongside the sample it was captured with.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_dat  <= '0;
      r_en1  <= 1'b0;
      r_inv1 <= 1'b0;
      r_d1   <= '0;
      r_en2  <= 1'b0;
      r_d2   <= '0;
    end else begin
      r_dat  <= adc_dat;
      r_en1  <= cfg_enable;
      r_inv1 <= cfg_invert;
      r_d1   <= (cfg_dlog2 > DW'(MAX_DLOG2)) ? DW'(MAX_DLOG2) : cfg_dlog2;
      r_en2  <= r_en1;
      r_d2   <= r_d1;
    end
  end

  // A D change abandons the frame in flight; that sample is discarded too.
  assign w_cmax = ~({MAX_DLOG2{1'b1}} << r_d2);
  assign w_clr  = !r_en2 || (r_d2 != r_dcur);
  assign w_last = (r_cnt == w_cmax);
  assign w_dump = !w_clr && w_last;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_cnt  <= '0;
      r_dcur <= '0;
    end else begin
      r_dcur <= r_d2;
      r_cnt  <= (w_clr || w_last) ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    axis_adc_decim_lane #(
      .ADC_WIDTH (ADC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .MAX_DLOG2 (MAX_DLOG2),
      .DW        (DW)
    ) u_lane (
      .aclk    (aclk),
      .aresetn (aresetn),
      .i_raw   (r_dat[g][ADC_WIDTH-1:0]),
      .i_inv   (r_inv1),
      .i_clr   (w_clr),
      .i_first (r_cnt == '0),
      .i_dlog2 (r_d2),
      .o_mean  (w_mean[g])
    );
  end

  // 1-deep output: a frame arriving while a beat is stalled is dropped and counted.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_ovr    <= '0;
    end else if (w_dump) begin
      if (!r_tvalid || m_axis_tready) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_mean;
      end else if (r_ovr != 16'hFFFF) begin
        r_ovr <= r_ovr + 16'd1;
      end
    end else if (r_tvalid && m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_adc_decim_frontend.sv
// Bench for axis_adc_decim_frontend: frame-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic and a long stall.
module tb_axis_adc_decim_frontend;
  localparam int NCH = 2;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          adc_csn;
  logic [31:0]   adc_dat = '0;
  logic          cfg_enable = 1'b0;
  logic          cfg_invert = 1'b0;
  logic [3:0]    cfg_dlog2 = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic [31:0]   m_axis_tdata;
  logic [15:0]   sts_overrun;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  axis_adc_decim_frontend dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .adc_csn       (adc_csn),
    .adc_dat       (adc_dat),
    .cfg_enable    (cfg_enable),
    .cfg_invert    (cfg_invert),
    .cfg_dlog2     (cfg_dlog2),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .sts_overrun   (sts_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NCH-1:0][13:0] raw;
    logic                 en;
    logic                 inv;
    logic [3:0]           d;
  } tup_t;

  tup_t             q[$];
  int               fsum[NCH];
  int               fcnt;
  int               mdcur;
  bit               exp_v;
  logic [NCH-1:0][15:0] exp_d;
  int               exp_ovr;

  function automatic int fmt(input logic [13:0] r, input logic inv);
    logic [13:0] v;
    v = inv ? {r[13], ~r[12:0]} : r;
    return int'($signed(v));
  endfunction

  function automatic int floor_div(input int s, input int n);
    int qq;
    qq = s / n;
    if ((s % n) != 0 && s < 0) qq = qq - 1;
    return qq;
  endfunction

  always @(posedge clk) begin
    tup_t cur;
    tup_t t;
    bit   dump;
    logic [NCH-1:0][15:0] mean;
    if (!aresetn) begin
      q.delete();
      q.push_back('0);
      q.push_back('0);
      for (int l = 0; l < NCH; l++) fsum[l] = 0;
      fcnt = 0; mdcur = 0; exp_v = 0; exp_d = '0; exp_ovr = 0;
    end else begin
      for (int l = 0; l < NCH; l++) cur.raw[l] = adc_dat[l*16 +: 14];
      cur.en  = cfg_enable;
      cur.inv = cfg_invert;
      cur.d   = (cfg_dlog2 > 4'd8) ? 4'd8 : cfg_dlog2;
      q.push_back(cur);
      t = q.pop_front();
      dump = 0;
      mean = '0;
      if (!t.en || int'(t.d) != mdcur) begin
        for (int l = 0; l < NCH; l++) fsum[l] = 0;
        fcnt = 0;
        mdcur = int'(t.d);
      end else begin
        for (int l = 0; l < NCH; l++) fsum[l] += fmt(t.raw[l], t.inv);
        fcnt++;
        if (fcnt == (1 << t.d)) begin
          for (int l = 0; l < NCH; l++) begin
            mean[l] = 16'(floor_div(fsum[l], 1 << t.d));
            fsum[l] = 0;
          end
          fcnt = 0;
          dump = 1;
        end
      end
      if (dump) begin
        if (!exp_v || m_axis_tready) begin
          exp_v = 1;
          exp_d = mean;
        end else if (exp_ovr < 16'hFFFF) begin
          exp_ovr++;
        end
      end else if (exp_v && m_axis_tready) begin
        exp_v = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("csn", 64'(adc_csn), 64'd1);
      chk("tvalid", 64'(m_axis_tvalid), 64'(exp_v));
      chk("tdata", 64'(m_axis_tdata), 64'(exp_d));
      chk("overrun", 64'(sts_overrun), 64'(exp_ovr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic feed(input int a, input int b);
    logic [13:0] x0, x1;
    logic [1:0]  h0, h1;
    x0 = 14'(a); x1 = 14'(b);
    h0 = 2'($urandom); h1 = 2'($urandom);
    adc_dat = {h1, x1, h0, x0};
    @(negedge clk);
  endtask

  task automatic feed_rand();
    adc_dat = $urandom;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cfg_enable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    aresetn = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_overrun", 64'(sts_overrun), 64'd0);
    chk("rst_csn", 64'(adc_csn), 64'd1);
    aresetn = 1'b1;

    // 1: D=0 passthrough, format correction, two-cycle latency
    cfg_dlog2 = 4'd0; cfg_invert = 1'b1; cfg_enable = 1'b1;
    adc_dat = {2'b00, 14'h2000, 2'b00, 14'h0000};
    @(negedge clk); @(negedge clk);
    chk("s1_lat_tvalid_lo", 64'(m_axis_tvalid), 64'd0);
    @(negedge clk);
    chk("s1_lat_tvalid_hi", 64'(m_axis_tvalid), 64'd1);
    chk("s1_inv_tdata", 64'(m_axis_tdata), 64'hFFFF_1FFF);
    cfg_invert = 1'b0;
    adc_dat = {2'b11, 14'h2000, 2'b10, 14'h3FFF};
    repeat (3) @(negedge clk);
    chk("s1_noinv_tdata", 64'(m_axis_tdata), 64'hE000_FFFF);

    // 2: D=2 mean, floor on negatives
    cfg_dlog2 = 4'd2; idle(3);
    cfg_enable = 1'b1;
    feed(4, 100); feed(8, 100); feed(-4, 100); feed(0, 100);
    idle(2);
    chk("s2_mean", 64'(m_axis_tdata), 64'h0064_0002);
    cfg_enable = 1'b1;
    feed(-1, 3); feed(0, 0); feed(0, 0); feed(0, 0);
    idle(2);
    chk("s2_floor", 64'(m_axis_tdata), 64'h0000_FFFF);

    // 3: stall for 10 dumps, then resume
    cfg_dlog2 = 4'd0; idle(1);
    cfg_enable = 1'b1; m_axis_tready = 1'b0;
    feed(123, -5);
    repeat (12) feed_rand();
    chk("s3_overrun10", 64'(sts_overrun), 64'd10);
    chk("s3_frozen", 64'(m_axis_tdata), 64'hFFFB_007B);
    chk("s3_tvalid", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    repeat (20) feed_rand();

    // 4: change D mid-frame
    cfg_dlog2 = 4'd3; idle(3);
    cfg_enable = 1'b1;
    repeat (5) feed_rand();
    cfg_dlog2 = 4'd1;
    feed_rand();
    feed(10, -3); feed(21, -4);
    idle(2);
    chk("s4_newd_mean", 64'(m_axis_tdata), 64'hFFFC_000F);
    chk("s4_overrun", 64'(sts_overrun), 64'd10);

    // 5: enable dropped mid-frame with a beat held
    cfg_dlog2 = 4'd2; idle(3);
    m_axis_tready = 1'b0; cfg_enable = 1'b1;
    repeat (6) feed_rand();
    cfg_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("s5_held", 64'(m_axis_tvalid), 64'd1);
    m_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("s5_accepted", 64'(m_axis_tvalid), 64'd0);
    cfg_enable = 1'b1;
    feed(8, -8); feed(8, -8); feed(8, -8); feed(9, -9);
    idle(2);
    chk("s5_restart", 64'(m_axis_tdata), 64'hFFF7_0008);

    // 6: reset with a held beat and overrun=3
    idle(3);
    aresetn = 1'b0; @(negedge clk); @(negedge clk);
    aresetn = 1'b1;
    cfg_dlog2 = 4'd0; cfg_enable = 1'b1; m_axis_tready = 1'b0;
    repeat (6) feed_rand();
    chk("s6_pre_overrun", 64'(sts_overrun), 64'd3);
    chk("s6_pre_tvalid", 64'(m_axis_tvalid), 64'd1);
    aresetn = 1'b0;
    @(negedge clk);
    chk("s6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("s6_rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("s6_rst_overrun", 64'(sts_overrun), 64'd0);
    chk("s6_rst_csn", 64'(adc_csn), 64'd1);
    aresetn = 1'b1;
    m_axis_tready = 1'b1;

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      adc_dat = $urandom;
      cfg_enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 19) == 0) cfg_invert = ~cfg_invert;
      if ($urandom_range(0, 39) == 0)
        cfg_dlog2 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      m_axis_tready = ($urandom_range(0, 9) < 7);
      aresetn = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    aresetn = 1'b1;

    // long stall to saturate the overrun counter
    cfg_dlog2 = 4'd0; cfg_enable = 1'b1; m_axis_tready = 1'b0;
    repeat (65545) feed_rand();
    chk("s6_saturate", 64'(sts_overrun), 64'hFFFF);
    m_axis_tready = 1'b1;
    repeat (5) feed_rand();
    chk("s6_sat_hold", 64'(sts_overrun), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
